// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: decoupling FIFO between the IFU and decode.
// Buffers {instruction, pc, pc_plus_4} tuples and presents the head entry
// show-ahead to decode with a valid/ready handshake. The IFU is throttled
// through stall, which rises early enough to absorb fetches already in flight.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module inst_fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter int SKID       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INST_WIDTH-1:0]      inst_in,
    input  logic [ADDR_WIDTH-1:0]      pc_in,
    input  logic [ADDR_WIDTH-1:0]      pc_plus_4_in,
    output logic                       stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic [ADDR_WIDTH-1:0]      pc_plus_4_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  overflow_reg, overflow_next;

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc4_mem  [DEPTH];

    logic full;
    logic empty;
    logic deq;
    logic enq;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Handshakes are void on a flush cycle: the fetch is wrong-path and the
    // head is being discarded anyway.
    assign deq = out_valid & out_ready & ~flush;
    assign enq = in_valid & (~full | (out_valid & out_ready)) & ~flush;

    assign out_valid     = ~empty;
    assign stall         = (count_reg >= CNT_W'(DEPTH - SKID));
    assign count         = count_reg;
    assign overflow_err  = overflow_reg;
    assign inst_out      = inst_mem[rd_ptr_reg];
    assign pc_out        = pc_mem[rd_ptr_reg];
    assign pc_plus_4_out = pc4_mem[rd_ptr_reg];

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(deq);
            wr_ptr_next = wr_ptr_reg + PTR_W'(enq);
            count_next  = count_reg + CNT_W'(enq) - CNT_W'(deq);
            if (in_valid & full & ~(out_valid & out_ready))
                overflow_next = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // One register slot per entry, written only when it is the enqueue target.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic we;
            assign we = enq & (wr_ptr_reg == PTR_W'(gi));

            // Entry storage; cleared on reset so the head reads 0 before any fill.
            always_ff @(posedge clk) begin
                if (reset) begin
                    inst_mem[gi] <= '0;
                    pc_mem[gi]   <= '0;
                    pc4_mem[gi]  <= '0;
                end else if (we) begin
                    inst_mem[gi] <= inst_in;
                    pc_mem[gi]   <= pc_in;
                    pc4_mem[gi]  <= pc_plus_4_in;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: expected head tuples are pushed to a
// scoreboard queue when the bench enqueues and popped when decode accepts.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic [31:0] pc_plus_4_in;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [3:0]  count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    logic [95:0] sb[$];
    logic        exp_ovf = 1'b0;

    inst_fetch_queue #(.DEPTH(8), .INST_WIDTH(32), .ADDR_WIDTH(32), .SKID(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .inst_in(inst_in), .pc_in(pc_in), .pc_plus_4_in(pc_plus_4_in),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .inst_out(inst_out), .pc_out(pc_out), .pc_plus_4_out(pc_plus_4_out),
        .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'hA5C3_0013 ^ {pc[15:0], pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the registered-state outputs
    // against the model, retire/accept entries in the model, advance.
    task automatic do_cycle(input logic rst, input logic fl, input logic iv,
                            input logic [31:0] pc, input logic rdy);
        logic        dq;
        logic        was_full;
        logic [95:0] e;
        reset = rst; flush = fl; in_valid = iv; out_ready = rdy;
        pc_in = pc; inst_in = mk_inst(pc); pc_plus_4_in = pc + 32'd4;
        #1;
        chk("count", 64'(count), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("stall", 64'(stall), 64'(sb.size() >= DEPTH - 2));
        chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
        was_full = (sb.size() == DEPTH);
        dq = !rst && !fl && rdy && (sb.size() != 0);
        if (dq) begin
            e = sb.pop_front();
            chk("inst_out", 64'(inst_out), 64'(e[95:64]));
            chk("pc_out", 64'(pc_out), 64'(e[63:32]));
            chk("pc_plus_4_out", 64'(pc_plus_4_out), 64'(e[31:0]));
            $display("deq pc=%0h inst=%0h pc4=%0h", pc_out, inst_out, pc_plus_4_out);
        end
        if (!rst && !fl && iv) begin
            if (!was_full || dq) begin
                sb.push_back({mk_inst(pc), pc, pc + 32'd4});
                $display("enq pc=%0h", pc);
            end else begin
                exp_ovf = 1'b1;
                $display("drop pc=%0h (queue full)", pc);
            end
        end
        if (rst || fl) sb.delete();
        if (rst) exp_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst_in = '0; pc_in = '0; pc_plus_4_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset inst_out", 64'(inst_out), 64'd0);
        chk("reset pc_out", 64'(pc_out), 64'd0);
        chk("reset pc_plus_4_out", 64'(pc_plus_4_out), 64'd0);

        // 1 fill with decode stalled
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'(4 * i), 1'b0);
        chk("fill head pc", 64'(pc_out), 64'd0);
        // 2 drain in order
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // 3 refill, then enqueue while full with a simultaneous dequeue
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'(4 * i), 1'b0);
        do_cycle(1'b0, 1'b0, 1'b1, 32'd32, 1'b1);
        // 4 overflow: enqueue while full with no dequeue
        do_cycle(1'b0, 1'b0, 1'b1, 32'd36, 1'b0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // 5 flush with five entries and a wrong-path fetch
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'(44 + 4 * i), 1'b0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'd40, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'(64 + 4 * i), 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // 6 streaming through pointer wrap, reset mid-stream
        for (int i = 0; i < 20; i++) begin
            if (i == 12) do_cycle(1'b1, 1'b0, 1'b1, 32'(200 + 4 * i), 1'b1);
            else         do_cycle(1'b0, 1'b0, 1'b1, 32'(200 + 4 * i), 1'b1);
        end
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
